// File: rtl/rtf65002_ilq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtf65002_ilq : circular fetch byte queue with head-instruction       |
// |                length decode, PG2 prefix handling and HOLD on jumps. |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module rtf65002_ilq #(
  parameter int         DEPTH  = 16,
  parameter int         FW     = 4,
  parameter int         MAXLEN = 7,
  parameter logic [7:0] PG2_OP = 8'h42
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       wr_i,
  input  logic [FW*8-1:0]            wdat_i,
  input  logic [$clog2(FW+1)-1:0]    wcnt_i,
  output logic                       full_o,
  output logic [8:0]                 op_o,
  input  logic [3:0]                 len_i,
  output logic [MAXLEN*8-1:0]        ins_o,
  output logic [3:0]                 len_o,
  output logic                       pg2_o,
  output logic                       valid_o,
  input  logic                       rd_i,
  output logic                       hold_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_q [DEPTH];
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_wp;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_run;
  logic          w_pg2;
  logic [4:0]    w_len_full;
  logic [4:0]    w_need;
  logic          w_enough;
  logic          w_valid;
  logic          w_err_set;
  logic          w_rd_fire;
  logic          w_wr_fire;
  logic [CW-1:0] w_wr_n;
  logic [CW-1:0] w_rd_n;

  assign w_run = (r_state == S_RUN);
  assign w_pg2 = (r_cnt != '0) && (r_q[r_rp] == PG2_OP);
  assign op_o  = w_pg2 ? {1'b1, r_q[r_rp + AW'(1)]} : {1'b0, r_q[r_rp]};

  // A zero table length marks a control transfer: retire just the opcode (and prefix).
  assign w_len_full = (len_i == 4'd0) ? 5'd0 : ({1'b0, len_i} + {4'd0, w_pg2});
  assign w_need     = (len_i == 4'd0) ? (5'd1 + {4'd0, w_pg2}) : w_len_full;
  assign w_enough   = (int'(r_cnt) >= int'(w_need)) &&
                      (int'(r_cnt) >= (w_pg2 ? 2 : 1));
  assign w_valid    = w_run && w_enough && (int'(w_len_full) <= MAXLEN);
  assign w_err_set  = w_run && w_enough && (int'(w_len_full) > MAXLEN);

  assign full_o    = int'(r_cnt) > (DEPTH - FW);
  assign w_rd_fire = rd_i && w_valid;
  assign w_wr_fire = wr_i && !full_o;
  assign w_wr_n    = w_wr_fire ? CW'(wcnt_i) : '0;
  assign w_rd_n    = w_rd_fire ? CW'(w_need) : '0;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_RUN;
    end else if (w_err_set || (w_rd_fire && (len_i == 4'd0))) begin
      w_state_nxt = S_HOLD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_RUN;
      r_rp    <= '0;
      r_wp    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= 8'h00;
      end
    end else begin
      r_state <= w_state_nxt;
      if (flush_i) begin
        r_rp  <= '0;
        r_wp  <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        for (int i = 0; i < FW; i++) begin
          if (w_wr_fire && (i < int'(wcnt_i))) begin
            r_q[r_wp + AW'(i)] <= wdat_i[i*8 +: 8];
          end
        end
        r_wp  <= r_wp + AW'(w_wr_n);
        r_rp  <= r_rp + AW'(w_rd_n);
        r_cnt <= r_cnt + w_wr_n - w_rd_n;
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ins_o = '0;
    for (int k = 0; k < MAXLEN; k++) begin
      ins_o[k*8 +: 8] = r_q[r_rp + AW'(k)];
    end
  end

  assign len_o   = w_len_full[3:0];
  assign pg2_o   = w_pg2;
  assign valid_o = w_valid;
  assign hold_o  = (r_state == S_HOLD);
  assign err_o   = r_err;
  assign count_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rtf65002_ilq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rtf65002_ilq : directed bench for rtf65002_ilq with a byte-queue  |
// |                   reference model and literal expectations.          |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_rtf65002_ilq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] wdat = '0;
  logic [2:0]  wcnt = '0;
  logic        full;
  logic [8:0]  op;
  logic [3:0]  len_i;
  logic [3:0]  len_o;
  logic [55:0] ins;
  logic        pg2;
  logic        valid;
  logic        hold;
  logic        err;
  logic [4:0]  count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mq[$];
  bit          m_hold = 1'b0;
  bit          m_err = 1'b0;

  string       lit_name[$];
  int          lit_sig[$];
  logic [63:0] lit_exp[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] tbl(input logic [8:0] o);
    case (o)
      9'h0EA:  return 4'd1;
      9'h018:  return 4'd1;
      9'h110:  return 4'd2;
      9'h04C:  return 4'd0;
      9'h099:  return 4'd9;
      9'h020:  return 4'd3;
      default: return 4'd1;
    endcase
  endfunction

  assign len_i = tbl(op);

  rtf65002_ilq dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .wr_i    (wr),
    .wdat_i  (wdat),
    .wcnt_i  (wcnt),
    .full_o  (full),
    .op_o    (op),
    .len_i   (len_i),
    .ins_o   (ins),
    .len_o   (len_o),
    .pg2_o   (pg2),
    .valid_o (valid),
    .rd_i    (rd),
    .hold_o  (hold),
    .err_o   (err),
    .count_o (count)
  );

  function automatic logic [63:0] sig_val(input int s);
    case (s)
      0:       return 64'(count);
      1:       return 64'(valid);
      2:       return 64'(len_o);
      3:       return 64'(full);
      4:       return 64'(hold);
      5:       return 64'(err);
      6:       return 64'(pg2);
      7:       return 64'(op);
      default: return 64'(ins);
    endcase
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_check();
    int          sz;
    bit          p;
    logic [8:0]  o;
    int          l;
    int          lf;
    int          nd;
    bit          ev;
    sz = mq.size();
    p  = (sz >= 1) && (mq[0] == 8'h42);
    ev = 1'b0;
    chk("count", 64'(count), 64'(sz));
    chk("full", 64'(full), 64'((16 - sz) < 4));
    chk("hold", 64'(hold), 64'(m_hold));
    chk("err", 64'(err), 64'(m_err));
    chk("pg2", 64'(pg2), 64'(p));
    if (sz >= (p ? 2 : 1)) begin
      o  = p ? {1'b1, mq[1]} : {1'b0, mq[0]};
      l  = int'(tbl(o));
      lf = (l == 0) ? 0 : l + int'(p);
      nd = (l == 0) ? 1 + int'(p) : lf;
      ev = !m_hold && (sz >= nd) && (lf <= 7);
      chk("op", 64'(op), 64'(o));
      chk("len", 64'(len_o), 64'(lf));
    end
    chk("valid", 64'(valid), 64'(ev));
    for (int k = 0; k < sz && k < 7; k++) begin
      chk("ins_byte", 64'(ins[k*8 +: 8]), 64'(mq[k]));
    end
  endtask

  // Single checking process: pinned literals first, then the model every cycle.
  always @(negedge clk) begin : compare
    string       n;
    int          s;
    logic [63:0] e;
    while (lit_sig.size() > 0) begin
      n = lit_name.pop_front();
      s = lit_sig.pop_front();
      e = lit_exp.pop_front();
      chk(n, sig_val(s), e);
    end
    if (rst_n) model_check();
  end

  task automatic lit(input string n, input int s, input logic [63:0] e);
    lit_name.push_back(n);
    lit_sig.push_back(s);
    lit_exp.push_back(e);
  endtask

  task automatic model_update(input bit f, input bit w, input logic [31:0] d,
                              input int c, input bit r);
    int         sz;
    bit         p;
    bit         full_m;
    logic [8:0] o;
    logic [7:0] dummy;
    int         l;
    int         lf;
    int         nd;
    if (f) begin
      mq.delete();
      m_hold = 1'b0;
      m_err  = 1'b0;
      return;
    end
    sz     = mq.size();
    full_m = (16 - sz) < 4;
    p      = (sz >= 1) && (mq[0] == 8'h42);
    if (!m_hold && sz >= (p ? 2 : 1)) begin
      o  = p ? {1'b1, mq[1]} : {1'b0, mq[0]};
      l  = int'(tbl(o));
      lf = (l == 0) ? 0 : l + int'(p);
      nd = (l == 0) ? 1 + int'(p) : lf;
      if (sz >= nd) begin
        if (lf > 7) begin
          m_err  = 1'b1;
          m_hold = 1'b1;
        end else if (r) begin
          for (int i = 0; i < nd; i++) dummy = mq.pop_front();
          if (l == 0) m_hold = 1'b1;
        end
      end
    end
    if (w && !full_m) begin
      for (int i = 0; i < c; i++) mq.push_back(d[i*8 +: 8]);
    end
  endtask

  task automatic cyc(input bit f, input bit w, input logic [31:0] d,
                     input int c, input bit r);
    flush = f;
    wr    = w;
    wdat  = d;
    wcnt  = 3'(c);
    rd    = r;
    @(posedge clk);
    model_update(f, w, d, c, r);
    #1;
    flush = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    wcnt  = '0;
    wdat  = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit("rst_count", 0, 0);
    lit("rst_valid", 1, 0);
    lit("rst_full", 3, 0);
    lit("rst_hold", 4, 0);
    lit("rst_err", 5, 0);
    lit("rst_pg2", 6, 0);
    lit("rst_op", 7, 0);
    lit("rst_ins", 8, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single-byte opcodes, write then drain
    cyc(0, 1, 32'h181818EA, 4, 0);
    lit("t1_valid", 1, 1);
    lit("t1_len", 2, 1);
    lit("t1_count", 0, 4);
    repeat (4) cyc(0, 0, 0, 0, 1);
    lit("t1_drain_count", 0, 0);
    lit("t1_drain_valid", 1, 0);

    // PG2 prefixed instruction
    cyc(0, 1, 32'h00001042, 2, 0);
    lit("t2_pg2", 6, 1);
    lit("t2_op", 7, 64'h110);
    lit("t2_valid_early", 1, 0);
    cyc(0, 1, 32'h00000055, 1, 0);
    lit("t2_valid", 1, 1);
    lit("t2_len", 2, 3);
    cyc(0, 0, 0, 0, 1);
    lit("t2_count", 0, 0);

    // fill to full, dropped write, wrap on refill
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h04030201 + 32'(i) * 32'h04040404, 4, 0);
    lit("t3_count16", 0, 16);
    lit("t3_full", 3, 1);
    cyc(0, 1, 32'hAAAAAAAA, 4, 0);
    lit("t3_drop_count", 0, 16);
    repeat (12) cyc(0, 0, 0, 0, 1);
    lit("t3_drain_count", 0, 4);
    lit("t3_drain_full", 3, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h14131211 + 32'(i) * 32'h04040404, 4, 0);
    lit("t3_refill_count", 0, 16);
    cyc(1, 0, 0, 0, 0);

    // control transfer enters HOLD
    cyc(0, 1, 32'h0018184C, 3, 0);
    lit("t4_valid", 1, 1);
    lit("t4_len", 2, 0);
    cyc(0, 0, 0, 0, 1);
    lit("t4_count", 0, 2);
    lit("t4_hold", 4, 1);
    cyc(0, 1, 32'h18181818, 4, 1);
    lit("t4_count_hold", 0, 6);
    lit("t4_valid_hold", 1, 0);
    cyc(1, 0, 0, 0, 0);
    lit("t4_flush_count", 0, 0);
    lit("t4_flush_hold", 4, 0);

    // over-long instruction sets sticky error
    cyc(0, 1, 32'h03020199, 4, 0);
    cyc(0, 1, 32'h07060504, 4, 0);
    cyc(0, 1, 32'h0B0A0908, 4, 0);
    lit("t5_err_pre", 5, 0);
    cyc(0, 0, 0, 0, 1);
    lit("t5_err", 5, 1);
    lit("t5_hold", 4, 1);
    lit("t5_valid", 1, 0);
    cyc(1, 0, 0, 0, 0);
    lit("t5_err_clr", 5, 0);
    lit("t5_hold_clr", 4, 0);

    // simultaneous read and write, then flush with write
    cyc(0, 1, 32'h03020120, 4, 0);
    cyc(0, 1, 32'h00000004, 1, 0);
    lit("t6_count5", 0, 5);
    lit("t6_len", 2, 3);
    cyc(0, 1, 32'h08070605, 4, 1);
    lit("t6_count6", 0, 6);
    cyc(1, 1, 32'h0C0B0A09, 4, 0);
    lit("t6_flush_wr", 0, 0);

    // asynchronous reset mid-operation
    cyc(0, 1, 32'h14131211, 4, 0);
    rst_n = 1'b0;
    mq.delete();
    m_hold = 1'b0;
    m_err  = 1'b0;
    lit("t7_count", 0, 0);
    lit("t7_valid", 1, 0);
    lit("t7_ins", 8, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 1, 32'h181818EA, 4, 0);
    lit("t7_after_count", 0, 4);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
